// File: rtl/q44_accumulator.sv
// -----------------------------------------------------------------------------
// q44_accumulator
//
// Sums every LEN consecutive accepted signed Q4.4 samples in a wide
// accumulator and emits the sum saturated back to Q4.4, with a flag that
// reports clamping. The result is held until the consumer accepts it.
//
// Parameters:
//   LEN    samples summed per result (>= 1)
//   ACC_W  accumulator width, >= 8 + ceil(log2(LEN)) so it never wraps
//
// Ports:
//   clk        system clock, rising-edge
//   rst_n      asynchronous reset, active-low
//   clr        synchronous clear of the partial sum (priority over accept)
//   din        sample, signed Q4.4
//   in_valid   din valid this cycle
//   in_ready   block can accept din this cycle
//   dout       result, signed Q4.4, saturated
//   ovf        true sum of the current result was outside [-128, 127] LSB
//   out_valid  dout/ovf hold a result
//   out_ready  consumer accepts the result this cycle
// -----------------------------------------------------------------------------
module q44_accumulator #(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [7:0] din,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] dout,
  output logic       ovf,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(LEN - 1);
  localparam logic signed [ACC_W-1:0] Q_MAX    = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Q_MIN    = ACC_W'(-128);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic                    last;
  logic [7:0]              sat_val;
  logic                    sat_hit;

  // A slot opens when no result is pending or the pending one drains this
  // edge; clr blocks input so a cleared cycle never absorbs a sample.
  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == LAST_CNT);

  assign din_ext  = ACC_W'($signed(din));
  assign sum      = acc + din_ext;

  // NOTE: every output gets a default before the if-chain so no path leaves
  // a variable unassigned, which would infer a latch.
  always_comb begin
    sat_val = sum[7:0];
    sat_hit = 1'b0;
    if (sum > Q_MAX) begin
      sat_val = 8'h7F;
      sat_hit = 1'b1;
    end else if (sum < Q_MIN) begin
      sat_val = 8'h80;
      sat_hit = 1'b1;
    end
  end

  // Partial-sum state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Result register. A drain and a final accept on the same edge reload the
  // output with the new result and keep out_valid high (no bubble); the later
  // assignment wins in that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout      <= 8'h00;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept && last) begin
        dout      <= sat_val;
        ovf       <= sat_hit;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/q44_accumulator.md
Name: q44_accumulator

Overview:
- Downstream stage of the Q4.4 saturating multiplier.
- Accepts a stream of signed Q4.4 products, eight bits each, with a valid/ready handshake.
- Sums every LEN consecutive accepted samples in a wide internal accumulator.
- Emits the sum saturated back to Q4.4 with an overflow flag and holds it until the consumer accepts it.
- Building block for small fixed-point dot products: multiplier -> accumulator -> consumer.

Parameters:
- LEN, 4: number of accepted samples summed per result; must be >= 1.
- ACC_W, 12: internal accumulator width in bits; must be >= 8 + ceil(log2(LEN)), so there is no internal wrap.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- clr  input  1  synchronous clear of the partial accumulation.
- din  input  8  sample, signed Q4.4 (two's complement, LSB = 1/16).
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  block can accept din this cycle.
- dout  output  8  result, signed Q4.4, saturated.
- ovf  output  1  the true sum of the current result was outside [-128, 127] LSB.
- out_valid  output  1  dout/ovf hold a result.
- out_ready  input  1  consumer accepts the result this cycle.

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc = 0, cnt = 0, dout = 8'h00, ovf = 0, out_valid = 0.
  - These values hold until the first rising edge after rst_n deasserts.
- in_ready = !clr && (!out_valid || out_ready). This is combinational, with no dependency on in_valid.
- Accept: in_valid && in_ready on a rising edge.
  - din is sign-extended to ACC_W; the sum is sum = acc + sext(din).
  - If cnt < LEN-1: acc <= sum, cnt <= cnt + 1.
  - If cnt == LEN-1 (final sample):
    - dout <= sat8(sum): 8'h7F if sum > 127, 8'h80 if sum < -128, otherwise sum[7:0].
    - ovf <= 1 if sum was clamped, otherwise 0.
    - out_valid <= 1, acc <= 0, cnt <= 0.
- Latency: the result is visible on the cycle after the edge that accepts the LEN-th sample.
- Output hold: while out_valid && !out_ready, dout and ovf are stable and in_ready = 0.
- Drain: on out_valid && out_ready, out_valid <= 0 unless a final sample is accepted on the same edge. In that case out_valid stays 1 and dout/ovf load the new result. Full throughput, no bubble.
- Simultaneous drain and non-final accept: the sample is accumulated and out_valid drops.
- clr:
  - acc <= 0, cnt <= 0.
  - in_ready is forced low, so a same-cycle din is not accepted.
  - A pending result (out_valid, dout, ovf) is unaffected and still drains through out_ready.
  - clr has priority over accept.
- No rounding is performed: input and output share the Q4.4 scale. Only saturation is applied.
- LEN == 1: every accepted sample produces a result, effectively a registered skid with an ovf that is always 0.
- dout changes only on a final accept or on reset. Outside a valid result its value is "don't care" to the consumer but deterministic.

Test Plan:
- Basic sum:
  - LEN=4, out_ready=1; accept 8'h10 x4 (1.0 each).
  - Expect dout=8'h40, ovf=0, out_valid high exactly one cycle after the 4th accept.
- Mixed signs:
  - Accept 8'h20, 8'hF0, 8'h08, 8'hF8 (32-16+8-8=16).
  - Expect dout=8'h10, ovf=0.
- Saturation:
  - Accept 8'h7F x4 (sum 508): expect dout=8'h7F, ovf=1.
  - Then 8'h80 x4 (sum -512): expect dout=8'h80, ovf=1.
  - Then 8'h7F, 8'h81, 8'h7F, 8'h81 (sum 0): expect dout=8'h00, ovf=0.
- Backpressure:
  - Complete a result with out_ready=0 for 5 cycles; expect in_ready=0 and dout/ovf stable throughout.
  - Raise out_ready with in_valid=1 on the same cycle; expect the sample accepted, out_valid dropping next cycle, and cnt=1.
  - Back-to-back: stream 8 samples with out_ready=1 and in_valid=1; expect two results on consecutive groups with no stall.
- clr:
  - Accept 8'h10 x2, pulse clr with in_valid=1 (sample not accepted), then accept 8'h08 x4.
  - Expect dout=8'h20.
  - Pulse clr while a result is pending; expect the result preserved until drained.
- Reset mid-operation:
  - After 3 accepts, and separately with out_valid=1, assert rst_n low between clock edges.
  - Expect out_valid=0, dout=8'h00, ovf=0 immediately, without a clock edge.
  - After release, 4 accepts of 8'h04 give dout=8'h10.
